// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the BCD display scheduler: FSM encoding, conversion
// limits and the active-low seven-segment patterns.
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  localparam int unsigned BCD_MAX    = 9999;
  localparam int unsigned SHIFT_ITER = 14;

  // Segment order {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // One double-dabble iteration: add 3 to each nibble >= 5 (no inter-nibble carry),
  // then shift left pulling in the next binary bit.
  function automatic logic [15:0] dabble_step(input logic [15:0] acc, input logic in_bit);
    logic [15:0] adj;
    adj = acc;
    for (int i = 0; i < 4; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
    return (adj << 1) | {15'd0, in_bit};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment decoder; non-BCD codes blank.
module seg7_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    unique case (digit)
      4'd0:    seg_n = SEG_0;
      4'd1:    seg_n = SEG_1;
      4'd2:    seg_n = SEG_2;
      4'd3:    seg_n = SEG_3;
      4'd4:    seg_n = SEG_4;
      4'd5:    seg_n = SEG_5;
      4'd6:    seg_n = SEG_6;
      4'd7:    seg_n = SEG_7;
      4'd8:    seg_n = SEG_8;
      4'd9:    seg_n = SEG_9;
      default: seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_display_scheduler.sv
// Round-robin shared serial binary-to-BCD converter for two requesters, with the latched
// result scanned onto a 4-digit common-anode seven-segment display.
module bcd_display_scheduler
  import bcd_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned VAL_W       = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic [VAL_W-1:0] val_a,
  output logic             ack_a,
  input  logic             req_b,
  input  logic [VAL_W-1:0] val_b,
  output logic             ack_b,
  output logic             busy,
  output logic [15:0]      bcd_out,
  output logic             bcd_src,
  output logic             ovf,
  output logic [3:0]       an_n,
  output logic [6:0]       seg_n
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  state_e      state_q, state_d;
  logic        grant_b_q, grant_b_d;
  logic        ptr_q, ptr_d;
  logic [3:0]  iter_q, iter_d;
  logic [13:0] shreg_q, shreg_d;
  logic [15:0] acc_q, acc_d;
  logic        ovf_pend_q, ovf_pend_d;
  logic [15:0] bcd_q, bcd_d;
  logic        src_q, src_d;
  logic        ovf_q, ovf_d;
  logic        ack_a_q, ack_a_d;
  logic        ack_b_q, ack_b_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       digit;

  logic             grant_b_now;
  logic [VAL_W-1:0] sel_val;
  logic             sel_ovf;
  logic [13:0]      sel_sat;

  // Pointer high means B has priority when both request.
  assign grant_b_now = req_b && (!req_a || ptr_q);
  assign sel_val     = grant_b_now ? val_b : val_a;
  assign sel_ovf     = 32'(sel_val) > BCD_MAX;
  assign sel_sat     = sel_ovf ? 14'(BCD_MAX) : 14'(sel_val);

  always_comb begin
    state_d    = state_q;
    grant_b_d  = grant_b_q;
    ptr_d      = ptr_q;
    iter_d     = iter_q;
    shreg_d    = shreg_q;
    acc_d      = acc_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    src_d      = src_q;
    ovf_d      = ovf_q;
    ack_a_d    = 1'b0;
    ack_b_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_a || req_b) begin
          grant_b_d  = grant_b_now;
          ptr_d      = !grant_b_now;
          shreg_d    = sel_sat;
          ovf_pend_d = sel_ovf;
          acc_d      = '0;
          iter_d     = '0;
          state_d    = StShift;
        end
      end
      StShift: begin
        acc_d   = dabble_step(acc_q, shreg_q[13]);
        shreg_d = {shreg_q[12:0], 1'b0};
        if (iter_q == 4'(SHIFT_ITER - 1)) begin
          state_d = StDone;
        end else begin
          iter_d = iter_q + 4'd1;
        end
      end
      StDone: begin
        bcd_d   = acc_q;
        src_d   = grant_b_q;
        ovf_d   = ovf_pend_q;
        ack_a_d = !grant_b_q;
        ack_b_d = grant_b_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Scan path runs independently of the converter.
  always_comb begin
    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      idx_d = idx_q;
    end
    digit = bcd_q[3:0];
    unique case (idx_q)
      2'd0: digit = bcd_q[3:0];
      2'd1: digit = bcd_q[7:4];
      2'd2: digit = bcd_q[11:8];
      2'd3: digit = bcd_q[15:12];
      default: digit = bcd_q[3:0];
    endcase
    an_d = ~(4'b0001 << idx_q);
  end

  seg7_decode u_seg7_decode (
    .digit (digit),
    .seg_n (seg_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      grant_b_q  <= 1'b0;
      ptr_q      <= 1'b0;
      iter_q     <= '0;
      shreg_q    <= '0;
      acc_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      src_q      <= 1'b0;
      ovf_q      <= 1'b0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      an_q       <= 4'b1110;
      seg_q      <= SEG_0;
    end else begin
      state_q    <= state_d;
      grant_b_q  <= grant_b_d;
      ptr_q      <= ptr_d;
      iter_q     <= iter_d;
      shreg_q    <= shreg_d;
      acc_q      <= acc_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      src_q      <= src_d;
      ovf_q      <= ovf_d;
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign ack_a   = ack_a_q;
  assign ack_b   = ack_b_q;
  assign busy    = (state_q != StIdle);
  assign bcd_out = bcd_q;
  assign bcd_src = src_q;
  assign ovf     = ovf_q;
  assign an_n    = an_q;
  assign seg_n   = seg_q;

endmodule

// File: tb/tb_bcd_display_scheduler.sv
// Scoreboard bench: stimulus queues expected results, a negedge monitor checks each ack.
module tb_bcd_display_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic [13:0] val_a = '0;
  logic [13:0] val_b = '0;
  logic        ack_a, ack_b, busy, bcd_src, ovf;
  logic [15:0] bcd_out;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;

  bcd_display_scheduler #(
    .REFRESH_DIV (4),
    .VAL_W       (14)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req_a   (req_a),
    .val_a   (val_a),
    .ack_a   (ack_a),
    .req_b   (req_b),
    .val_b   (val_b),
    .ack_b   (ack_b),
    .busy    (busy),
    .bcd_out (bcd_out),
    .bcd_src (bcd_src),
    .ovf     (ovf),
    .an_n    (an_n),
    .seg_n   (seg_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        src;
    logic [15:0] bcd;
    logic        ovf;
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   acks_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every ack must match the oldest queued expectation.
  always @(negedge clk) begin
    if (ack_a || ack_b) begin
      acks_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack_a=%0b ack_b=%0b bcd=%0h expected no ack",
                 ack_a, ack_b, bcd_out);
      end else begin
        mon_e = sb.pop_front();
        chk("ack_pair", {30'd0, ack_a, ack_b}, mon_e.src ? 32'd1 : 32'd2);
        chk("bcd_out", {16'd0, bcd_out}, {16'd0, mon_e.bcd});
        chk("bcd_src", {31'd0, bcd_src}, {31'd0, mon_e.src});
        chk("ovf", {31'd0, ovf}, {31'd0, mon_e.ovf});
        if (mon_e.at >= 0) chk("ack_cycle", cyc, mon_e.at);
      end
    end
  end

  task automatic push(input logic src, input logic [15:0] bcd, input logic o, input int at);
    exp_t e;
    e.src = src;
    e.bcd = bcd;
    e.ovf = o;
    e.at  = at;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_acks(input int n, input int budget, input string name);
    int got;
    got = 0;
    for (int i = 0; i < budget && got < n; i++) begin
      @(negedge clk);
      if (ack_a || ack_b) got++;
    end
    chk(name, got, n);
  endtask

  // Called at a negedge with the engine idle; returns the grant edge's cycle number.
  task automatic start(input logic port, input logic [13:0] v, output int g);
    if (port) begin
      req_b = 1'b1;
      val_b = v;
    end else begin
      req_a = 1'b1;
      val_a = v;
    end
    @(posedge clk);
    #1 g = cyc;
  endtask

  task automatic convert(input logic port, input logic [13:0] v, input logic [15:0] exp_bcd,
                         input logic exp_ovf, input string name);
    int g;
    start(port, v, g);
    push(port, exp_bcd, exp_ovf, g + 15);
    @(negedge clk);
    req_a = 1'b0;
    req_b = 1'b0;
    wait_acks(1, 30, name);
  endtask

  logic [3:0] exp_an[4];
  logic [6:0] exp_seg[4];

  initial begin
    int g;
    int busy_bad;
    int a0;
    logic [3:0] prev;
    logic found;

    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_seg = '{7'b0010000, 7'b1111001, 7'b0000000, 7'b1000000};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bcd", {16'd0, bcd_out}, 32'd0);
    chk("rst_src", {31'd0, bcd_src}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_acks", {30'd0, ack_a, ack_b}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_an", {28'd0, an_n}, 32'h0000000e);
    chk("rst_seg", {25'd0, seg_n}, 32'h00000040);
    reset = 1'b0;

    // Single conversion: latency and busy window.
    @(negedge clk);
    start(1'b0, 14'd1234, g);
    push(1'b0, 16'h1234, 1'b0, g + 15);
    busy_bad = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (k == 0) req_a = 1'b0;
      if (busy !== 1'b1) busy_bad++;
    end
    chk("busy_window", busy_bad, 0);
    wait_acks(1, 5, "t1_ack");
    chk("busy_after_ack", {31'd0, busy}, 32'd0);

    // Both requesting continuously: strict alternation starting from A.
    do_reset();
    req_a = 1'b1;
    val_a = 14'd42;
    req_b = 1'b1;
    val_b = 14'd9999;
    @(posedge clk);
    #1 g = cyc;
    push(1'b0, 16'h0042, 1'b0, g + 15);
    push(1'b1, 16'h9999, 1'b0, g + 31);
    push(1'b0, 16'h0042, 1'b0, g + 47);
    push(1'b1, 16'h9999, 1'b0, g + 63);
    wait_acks(4, 80, "alt_acks");
    req_a = 1'b0;
    req_b = 1'b0;

    // Saturation boundaries.
    convert(1'b1, 14'd16383, 16'h9999, 1'b1, "sat_max");
    convert(1'b1, 14'd0, 16'h0000, 1'b0, "zero");
    convert(1'b0, 14'd10000, 16'h9999, 1'b1, "sat_10000");
    convert(1'b0, 14'd9999, 16'h9999, 1'b0, "exact_9999");

    // Reset in cycle 7 of a conversion aborts it silently.
    start(1'b0, 14'd5678, g);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 0) req_a = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_bcd", {16'd0, bcd_out}, 32'd0);
    a0 = acks_seen;
    repeat (25) @(negedge clk);
    chk("abort_no_ack", acks_seen - a0, 0);
    convert(1'b0, 14'd5678, 16'h5678, 1'b0, "after_abort");

    // Value is captured only at grant.
    start(1'b0, 14'd100, g);
    push(1'b0, 16'h0100, 1'b0, g + 15);
    repeat (3) @(negedge clk);
    val_a = 14'd200;
    wait_acks(1, 20, "t6_ack");
    req_a = 1'b0;

    // Display scan of 0819.
    convert(1'b0, 14'd819, 16'h0819, 1'b0, "scan_val");
    prev  = an_n;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (an_n == 4'b1110 && prev != 4'b1110) found = 1'b1;
      else prev = an_n;
    end
    chk("scan_sync", {31'd0, found}, 32'd1);
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        chk("scan_an", {28'd0, an_n}, {28'd0, exp_an[d]});
        chk("scan_seg", {25'd0, seg_n}, {25'd0, exp_seg[d]});
        @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
